// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
//   mux_mode_e : run-time mode selector (static select or round-robin)
//   next_idx   : channel index increment that wraps n-1 back to 0
package stream_mux_pkg;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_e;

  // Next channel after idx in a ring of n channels.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : per-channel request vector
//   ptr       : highest-priority channel index this cycle (must be < NUM_CH)
//   grant     : one-hot grant, zero when no request
//   gidx      : index of the granted channel (0 when no request)
//   any_grant : at least one request was granted
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  gidx,
  output logic              any_grant
);

  localparam int unsigned DBL_W = 2 * NUM_CH;

  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] masked;
  logic [DBL_W-1:0]  dbl;

  // Lower half keeps only requests at or above ptr; upper half holds the full
  // request vector so a scan from bit 0 naturally wraps past NUM_CH-1.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
    masked = req & mask;
    dbl    = {req, masked};
  end

  // Lowest set bit of the doubled vector is the winner; fold it back to a channel.
  always_comb begin
    any_grant = 1'b0;
    gidx      = '0;
    for (int unsigned k = 0; k < DBL_W; k++) begin
      if (dbl[k] && !any_grant) begin
        any_grant = 1'b1;
        gidx      = (k >= NUM_CH) ? SEL_W'(k - NUM_CH) : SEL_W'(k);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any_grant) begin
      grant = NUM_CH'(1) << gidx;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage; static select or round-robin arbitration chosen at run time.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 = static select via sel, 1 = round-robin
//   sel        : channel used in static mode (>= NUM_CH selects nothing)
//   in_data    : flattened channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, at most one bit set)
//   out_data   : registered output word
//   out_valid  : registered output valid
//   out_ready  : consumer ready
//   out_ch     : channel that supplied out_data
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  mux_mode_e          mode_c;
  logic [NUM_CH-1:0]  req_c;
  logic [NUM_CH-1:0]  grant_c;
  logic [SEL_W-1:0]   gidx_c;
  logic               any_grant_c;
  logic               load_c;
  logic               accept_c;
  logic [WIDTH-1:0]   sel_data_c;

  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   rr_ptr_d;
  logic               out_valid_d;
  logic [WIDTH-1:0]   out_data_d;
  logic [SEL_W-1:0]   out_ch_d;

  assign mode_c = mux_mode_e'(mode);

  // Request vector: all valids in round-robin, only the selected one in static.
  always_comb begin
    req_c = '0;
    if (mode_c == MODE_RR) begin
      req_c = in_valid;
    end else if (32'(sel) < NUM_CH) begin
      req_c[sel] = in_valid[sel];
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req       (req_c),
    .ptr       (rr_ptr),
    .grant     (grant_c),
    .gidx      (gidx_c),
    .any_grant (any_grant_c)
  );

  // The output register can take a new word when empty or being drained.
  assign load_c   = !out_valid || out_ready;
  assign accept_c = any_grant_c && load_c;
  assign in_ready = grant_c & {NUM_CH{load_c}};

  // One-hot AND-OR select so unselected (possibly X) channels never reach out_data.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_c[i]) begin
        sel_data_c = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_ch_d    = out_ch;
    rr_ptr_d    = rr_ptr;
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_c;
      out_ch_d    = gidx_c;
      if (mode_c == MODE_RR) begin
        rr_ptr_d = SEL_W'(next_idx(32'(gidx_c), NUM_CH));
      end
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_ch    <= out_ch_d;
      rr_ptr    <= rr_ptr_d;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two run-time modes: static select, or round-robin arbitration across the channels.
- Has a single registered output stage, so latency is one cycle and throughput is one word per cycle.
- Successor to the combinational 3-bit muxes. Sits between producer channels and a single consumer (display/ALU datapath).

Parameters:
- NUM_CH, 4, number of input channels (at least 2; need not be a power of two).
- WIDTH, 3, data width per channel in bits.
- SEL_W, $clog2(NUM_CH), select/channel-index width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = static select via sel; 1 = round-robin.
- sel  in  SEL_W  channel index used in static mode.
- in_data  in  NUM_CH*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready (combinational).
- out_data  out  WIDTH  registered output word.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.
- out_ch  out  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, so channel 0 has highest priority first.
- Load enable: load = !out_valid | out_ready.
- Static mode (mode=0):
  - The request vector is in_valid masked to bit sel.
  - If sel >= NUM_CH, there is no request: no grant, all in_ready=0.
- Round-robin mode (mode=1):
  - The request vector is in_valid.
  - Grant goes to the first requesting channel found scanning upward from rr_ptr, wrapping NUM_CH-1 -> 0.
- Ready: in_ready[i] = grant[i] & load. At most one in_ready bit is high in any cycle. in_ready never depends on in_valid[i] of the same channel except through the grant.
- Accept: occurs when a grant exists and load=1. On the next edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
- Round-robin pointer:
  - After an accept in round-robin mode, rr_ptr <= (g == NUM_CH-1) ? 0 : g+1.
  - In static mode, rr_ptr is unchanged.
- Drain: if out_valid & out_ready with no accept, then out_valid <= 0. out_data and out_ch hold their last values.
- Stall: while out_valid & !out_ready, out_data, out_ch and out_valid are held stable and all in_ready=0.
- Simultaneous drain and accept: the output register is replaced in the same cycle, giving full throughput with no bubble.
- Latency: accept at edge k, word visible on out_* after edge k (one cycle).
- mode/sel changes:
  - They take effect on the next grant evaluation. The held output word is never altered.
  - A mode change does not reset rr_ptr.
- Reset mid-transfer: the held word is discarded, out_valid drops asynchronously, rr_ptr returns to 0.
- No X-propagation: unselected in_data may be X without affecting out_data.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {MODE_STATIC=1'b0, MODE_RR=1'b1} mux_mode_e.
  - Helper function for pointer wrap (next_idx(idx, n)).
- Sub-module rr_arbiter #(NUM_CH):
  - Purely combinational.
  - Inputs: req[NUM_CH], ptr[SEL_W].
  - Outputs: one-hot grant[NUM_CH], grant index gidx, any_grant.
  - Implemented with the double-width mask-and-priority technique.
- The top level holds the output register, rr_ptr, mode/sel masking and the ready logic.

Test Plan:
- Reset and static select:
  - Stimulus: reset asserted, then mode=0, sel=2, in_valid=4'b1111, in_data ch0..3 = 1,2,3,4, out_ready=1.
  - Response: after reset out_valid=0. One cycle later out_data=3 and out_ch=2 every cycle; in_ready=4'b0100.
- Round-robin fairness:
  - Stimulus: mode=1, all valid, out_ready=1.
  - Response: out_ch sequence 0,1,2,3,0,1; out_valid continuously 1 with no bubbles.
- Sparse requesters and wrap:
  - Stimulus: mode=1, in_valid=4'b1001.
  - Response: out_ch alternates 0,3,0,3. Then in_valid=4'b0100 only: out_ch=2 every cycle.
- Backpressure:
  - Stimulus: mode=1, all valid, out_ready=0 for 3 cycles after first accept.
  - Response: out_data/out_ch frozen at ch0's word, in_ready=0 for those cycles. On out_ready=1, ch1 is accepted the same cycle.
- Invalid sel and empty:
  - Stimulus: NUM_CH=3, mode=0, sel=3; then mode=1, in_valid=0.
  - Response: in_ready=0 in both cases; out_valid falls to 0 after the pending word drains.
- Async reset mid-stream:
  - Stimulus: rst_n pulled low between clock edges while out_valid=1, rr_ptr=2.
  - Response: out_valid=0 immediately. After release, the first round-robin grant goes to ch0.
